// File: rtl/apb_master_fsm.sv
// apb_master_fsm: APB initiator sequencing SETUP/ACCESS with decode, wait-state timeout and response strobe
module apb_master_fsm #(
  parameter int WAIT_LIMIT = 16,
  parameter int CNT_W      = $clog2(WAIT_LIMIT) + 1
) (
  input  logic        hclk,
  input  logic        hreset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        pwrite,
  output logic        penable,
  output logic [2:0]  psel,
  output logic [31:0] paddr,
  output logic [31:0] pwdata,
  input  logic [31:0] prdata,
  input  logic        pready,
  input  logic        pslverr
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  state_t state_q, state_d;
  logic [2:0] sel_q, sel_d, dec;
  logic pwrite_q, pwrite_d, err_q, err_d;
  logic [31:0] paddr_q, paddr_d, pwdata_q, pwdata_d, rdata_q, rdata_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb dec = req_addr[31:26] == 6'b100000 ? 3'b001 :
                    req_addr[31:26] == 6'b100001 ? 3'b010 :
                    req_addr[31:26] == 6'b100010 ? 3'b100 : 3'b000;
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    pwrite_d = pwrite_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: if (req_valid) begin
        sel_d    = dec;
        pwrite_d = req_write;
        paddr_d  = req_addr;
        pwdata_d = req_write ? req_wdata : 32'd0;
        err_d    = dec == 3'b000;
        rdata_d  = 32'd0;
        state_d  = dec == 3'b000 ? RESP : SETUP;
      end
      SETUP: begin
        cnt_d   = '0;
        state_d = ACCESS;
      end
      ACCESS: if (pready) begin
        err_d   = pslverr;
        rdata_d = (!pwrite_q && !pslverr) ? prdata : 32'd0;
        state_d = RESP;
      end else if (cnt_q == CNT_W'(WAIT_LIMIT - 1)) begin
        err_d   = 1'b1;
        rdata_d = 32'd0;
        state_d = RESP;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q  <= IDLE;
      sel_q    <= 3'b000;
      pwrite_q <= 1'b0;
      paddr_q  <= 32'd0;
      pwdata_q <= 32'd0;
      rdata_q  <= 32'd0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      pwrite_q <= pwrite_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end
  assign req_ready = state_q == IDLE;
  assign rsp_valid = state_q == RESP;
  assign rsp_rdata = rsp_valid ? rdata_q : 32'd0;
  assign rsp_err   = rsp_valid & err_q;
  assign psel      = (state_q == SETUP || state_q == ACCESS) ? sel_q : 3'b000;
  assign penable   = state_q == ACCESS;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
endmodule

// File: tb/tb_apb_master_fsm.sv
// tb_apb_master_fsm: directed plus randomized APB transactions checked against a transaction-level model
module tb_apb_master_fsm;
  localparam int WL = 16;
  logic hclk = 1'b0, hreset = 1'b1, req_valid = 1'b0, req_write = 1'b0;
  logic pready = 1'b0, pslverr = 1'b0;
  logic [31:0] req_addr = 32'd0, req_wdata = 32'd0, prdata = 32'd0;
  logic req_ready, rsp_valid, rsp_err, pwrite, penable;
  logic [31:0] rsp_rdata, paddr, pwdata;
  logic [2:0] psel;
  int compared = 0, mismatched = 0;

  always #5 hclk = ~hclk;

  apb_master_fsm #(.WAIT_LIMIT(WL)) dut (
    .hclk(hclk), .hreset(hreset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .pwrite(pwrite), .penable(penable), .psel(psel), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge hclk);
    @(negedge hclk);
  endtask

  // Slave index is the address region number minus 32; regions 32..34 exist
  function automatic logic [2:0] exp_sel(input logic [31:0] a);
    int t;
    t = int'(a[31:26]);
    return (t >= 32 && t <= 34) ? 3'(1 << (t - 32)) : 3'b000;
  endfunction

  task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input int waits, input logic se, input logic [31:0] rd);
    logic [2:0] s;
    logic [31:0] er, ewd;
    logic ee;
    int n;
    s   = exp_sel(a);
    n   = waits < WL ? waits + 1 : WL;
    ee  = s == 3'b000 || waits >= WL || se;
    er  = (s != 3'b000 && waits < WL && !w && !se) ? rd : 32'd0;
    ewd = w ? d : 32'd0;
    chk("idle_ready", req_ready, 1);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    step();
    req_valid = 1'b0; req_write = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    chk("busy_ready", req_ready, 0);
    if (s != 3'b000) begin
      chk("setup_psel", psel, s);
      chk("setup_penable", penable, 0);
      chk("setup_paddr", paddr, a);
      chk("setup_pwrite", pwrite, w);
      chk("setup_pwdata", pwdata, ewd);
      chk("setup_rsp_valid", rsp_valid, 0);
      step();
      for (int k = 0; k < n; k++) begin
        pready  = k == waits;
        pslverr = k == waits ? se : 1'($urandom);
        prdata  = k == waits ? rd : $urandom;
        chk("access_penable", penable, 1);
        chk("access_psel", psel, s);
        chk("access_paddr", paddr, a);
        chk("access_pwdata", pwdata, ewd);
        chk("access_rsp_valid", rsp_valid, 0);
        step();
      end
      pready = 1'b0; pslverr = 1'b0; prdata = $urandom;
      chk("resp_psel", psel, 0);
      chk("resp_penable", penable, 0);
    end else begin
      chk("decerr_psel", psel, 0);
    end
    chk("resp_valid", rsp_valid, 1);
    chk("resp_err", rsp_err, ee);
    chk("resp_rdata", rsp_rdata, er);
    step();
    chk("post_valid", rsp_valid, 0);
    chk("post_err", rsp_err, 0);
    chk("post_rdata", rsp_rdata, 0);
    chk("post_ready", req_ready, 1);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_psel"}, psel, 0);
    chk({tag, "_penable"}, penable, 0);
    chk({tag, "_pwrite"}, pwrite, 0);
    chk({tag, "_paddr"}, paddr, 0);
    chk({tag, "_pwdata"}, pwdata, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
    chk({tag, "_rsp_err"}, rsp_err, 0);
    chk({tag, "_req_ready"}, req_ready, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] top;
    int r, waits;
    repeat (2) @(posedge hclk);
    @(negedge hclk);
    chk_reset_state("reset");
    hreset = 1'b0;
    step();
    txn(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 0, 1'b0, 32'd0);
    txn(1'b0, 32'h8400_0004, 32'd0, 3, 1'b0, 32'h0000_00A5);
    txn(1'b0, 32'h0000_1000, 32'd0, 0, 1'b0, 32'd0);
    txn(1'b0, 32'h8800_0000, 32'd0, 0, 1'b1, 32'h1234_5678);
    txn(1'b1, 32'h8000_0100, 32'h0000_0055, WL, 1'b0, 32'd0);
    txn(1'b0, 32'h8000_0200, 32'd0, 1, 1'b0, 32'h0000_CAFE);
    txn(1'b0, 32'h8400_0300, 32'd0, WL - 1, 1'b0, 32'h0BAD_F00D);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h8400_0008; req_wdata = 32'h1111_2222;
    step();
    req_valid = 1'b0;
    step();
    step();
    hreset = 1'b1;
    step();
    chk_reset_state("midreset");
    hreset = 1'b0;
    step();
    chk("midreset_after_valid", rsp_valid, 0);
    chk("midreset_after_ready", req_ready, 1);
    chk("midreset_after_psel", psel, 0);
    for (int i = 0; i < 30; i++) begin
      r = $urandom_range(0, 4);
      top = r < 3 ? 6'(32 + r) : r == 3 ? 6'($urandom) : 6'h21;
      waits = $urandom_range(0, 7) == 0 ? $urandom_range(WL - 2, WL + 4) : $urandom_range(0, 4);
      txn(1'($urandom), {top, 26'($urandom)}, $urandom, waits, $urandom_range(0, 3) == 0, $urandom);
      repeat ($urandom_range(0, 2)) step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/apb_master_fsm.md
Name: apb_master_fsm

Overview:
- APB initiator (bridge-side) that drives the APB bus sampled by the existing APB slave-side interface.
- Accepts single read/write commands on a valid/ready request port and decodes the address to one of three one-hot slave selects.
- Sequences the APB SETUP and ACCESS phases, honouring PREADY wait states with a bounded timeout.
- Returns read data and error status on a one-cycle response strobe.

Parameters:
- WAIT_LIMIT, 16, maximum number of ACCESS cycles before timeout abort (≥1).
- CNT_W, $clog2(WAIT_LIMIT)+1, width of the wait-state counter (derived; do not override).

Ports:
- hclk  input  1  bus clock; all state changes on rising edge
- hreset  input  1  synchronous active-high reset
- req_valid  input  1  command present
- req_ready  output  1  block can accept a command (high only in IDLE)
- req_write  input  1  1 = write, 0 = read
- req_addr  input  32  byte address
- req_wdata  input  32  write data
- rsp_valid  output  1  one-cycle completion strobe
- rsp_rdata  output  32  read data (0 for writes and errors)
- rsp_err  output  1  completion had an error (decode, PSLVERR or timeout)
- pwrite  output  1  APB direction
- penable  output  1  APB enable
- psel  output  3  APB one-hot slave select
- paddr  output  32  APB address
- pwdata  output  32  APB write data
- prdata  input  32  APB read data
- pready  input  1  slave ready
- pslverr  input  1  slave error, valid with pready in ACCESS

Behaviour:
- Reset (hreset=1 at an edge):
  - State goes to IDLE.
  - Outputs return to their reset values: psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=1.
  - The wait counter clears to 0.
  - Reset mid-transaction aborts the transfer immediately with no response.
- Address decode (combinational from req_addr[31:26]):
  - 6'b100000 -> psel 3'b001
  - 6'b100001 -> psel 3'b010
  - 6'b100010 -> psel 3'b100
  - any other value -> decode error.
- States: IDLE, SETUP, ACCESS, RESP.
- IDLE: req_ready=1. On req_valid=1, latch write/addr/wdata/decoded psel.
  - Valid decode -> SETUP.
  - Decode error -> RESP with err=1. No APB activity: psel remains 0.
- SETUP (exactly 1 cycle):
  - Drive psel=decoded value, penable=0, paddr, pwrite and pwdata (pwdata=latched wdata for writes, 0 for reads).
  - Always go to ACCESS.
  - Clear wait counter.
- ACCESS:
  - psel, paddr, pwrite and pwdata are held stable; penable=1.
  - pready=1 -> RESP. Capture err=pslverr. Capture rdata=prdata only if read and pslverr=0, else 0.
  - pready=0 and counter==WAIT_LIMIT-1 -> RESP with err=1, rdata=0 (timeout).
  - Otherwise increment the counter and stay.
  - ACCESS therefore lasts at most WAIT_LIMIT cycles.
- Leaving ACCESS: psel=0 and penable=0 in the next cycle. There is no back-to-back SETUP.
- RESP (exactly 1 cycle):
  - rsp_valid=1 with the captured rsp_rdata and rsp_err.
  - Next state IDLE.
  - rsp_rdata and rsp_err return to 0 with rsp_valid.
- Latency, no wait states: accept edge N; SETUP in cycle N+1; ACCESS in N+2; rsp_valid in N+3; req_ready high again in N+4.
- Each added pready-low cycle adds one cycle.
- The response has no backpressure. Commands presented while req_ready=0 are ignored; the requester holds them.
- paddr and pwdata retain their last values in IDLE. Only psel and penable are required low.

Test Plan:
- Write, zero wait:
  - Stimulus: req addr 0x8000_0010, wdata 0xDEAD_BEEF, pready tied 1.
  - Response: SETUP psel=001 penable=0; next cycle penable=1; rsp_valid at N+3 with err=0, rdata=0.
- Read, 3 wait states:
  - Stimulus: addr 0x8400_0004 (psel=010), pready low 3 ACCESS cycles then high with prdata=0x0000_00A5.
  - Response: rsp_rdata=0x0000_00A5, err=0; paddr stable through all ACCESS cycles.
- Decode error:
  - Stimulus: addr 0x0000_1000.
  - Response: psel never asserted; rsp_valid one cycle after accept with err=1, rdata=0.
- Slave error:
  - Stimulus: read to 0x8800_0000 (psel=100), pready=1 with pslverr=1, prdata=0x1234_5678.
  - Response: rsp_err=1, rsp_rdata=0.
- Timeout:
  - Stimulus: pready held 0, WAIT_LIMIT=16.
  - Response: exactly 16 ACCESS cycles; then psel=0, penable=0; rsp_valid with err=1.
  - Follow-up: a subsequent command completes normally.
- Reset mid-ACCESS:
  - Stimulus: assert hreset during a wait state.
  - Response: all outputs at reset values next edge; no rsp_valid; req_ready=1.
